// File: rtl/register_pipe_oe_pkg.sv
// Shared types for the register pipe: occupancy-counter update encoding.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package register_pipe_oe_pkg;

  // How the occupancy counter moves on the next edge.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2,
    CNT_CLR  = 2'd3
  } cnt_op_e;

  // A clear wins over traffic. A simultaneous push and pop leaves the level unchanged.
  function automatic cnt_op_e cnt_op(input logic flush, input logic up, input logic dn);
    if (flush) begin
      return CNT_CLR;
    end
    if (up && !dn) begin
      return CNT_INC;
    end
    if (dn && !up) begin
      return CNT_DEC;
    end
    return CNT_HOLD;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid/data register pair with load enable and synchronous clear.
// Latency: 1 cycle from a load to the registered output.
// Backpressure: none locally; the parent withholds ld_i to stall the stage.
module pipe_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  ld_i,
  input  logic                  vld_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  vld_o,
  output logic [DATA_WIDTH-1:0] dat_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;

  // Next-state: a clear drops the valid bit but keeps the payload. Data only moves with a valid word.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (ld_i) begin
      valid_d = vld_i;
      if (vld_i) begin
        data_d = dat_i;
      end
    end
  end

  // State register with synchronous reset of both valid and payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign vld_o = valid_q;
  assign dat_o = data_q;

endmodule

// File: rtl/register_pipe_oe.sv
// DEPTH-stage valid/ready register pipeline with collapsing bubbles and a gated output payload.
// Latency: DEPTH cycles from upstream accept to valid_o while ready_i is held high. Full throughput.
// Backpressure: ready_o = ~full | ready_i (combinational); flush and reset force both handshakes low.
module register_pipe_oe
  import register_pipe_oe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [DATA_WIDTH-1:0]        data_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  input  logic                         OE_i,
  output logic [DATA_WIDTH-1:0]        data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DEPTH-1:0]      vld_q;
  logic [DATA_WIDTH-1:0] dat_q [DEPTH];
  logic [DEPTH:0]        rdy;

  logic                  up_xfer;
  logic                  dn_xfer;
  logic [CNT_W-1:0]      count_q, count_d;

  // Readiness ripples back from the output. An empty stage is always ready, so bubbles collapse.
  always_comb begin
    logic r;
    r          = ready_i;
    rdy        = '0;
    rdy[DEPTH] = r;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      r      = ~vld_q[k] | r;
      rdy[k] = r;
    end
  end

  // Stage 0 is fed from the upstream port. Every later stage is fed from its predecessor.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic                  up_vld;
    logic [DATA_WIDTH-1:0] up_dat;

    if (k == 0) begin : g_head
      assign up_vld = valid_i;
      assign up_dat = data_i;
    end else begin : g_body
      assign up_vld = vld_q[k-1];
      assign up_dat = dat_q[k-1];
    end

    pipe_stage #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .clr_i (flush_i),
      .ld_i  (rdy[k]),
      .vld_i (up_vld),
      .dat_i (up_dat),
      .vld_o (vld_q[k]),
      .dat_o (dat_q[k])
    );
  end

  // External handshakes are masked during flush/reset so no word is accepted or emitted then.
  always_comb begin
    ready_o = rdy[0] & ~flush_i & ~rst;
    valid_o = vld_q[DEPTH-1] & ~flush_i & ~rst;
    data_o  = '0;
    if (OE_i && valid_o) begin
      data_o = dat_q[DEPTH-1];
    end
  end

  assign up_xfer = valid_i & ready_o;
  assign dn_xfer = valid_o & ready_i;

  // Occupancy follows the port handshakes. It is clamped at both ends so it can never wrap.
  always_comb begin
    count_d = count_q;
    unique case (cnt_op(flush_i, up_xfer, dn_xfer))
      CNT_INC: begin
        if (count_q != CNT_MAX) begin
          count_d = count_q + CNT_ONE;
        end
      end
      CNT_DEC: begin
        if (count_q != '0) begin
          count_d = count_q - CNT_ONE;
        end
      end
      CNT_CLR:  count_d = '0;
      default:  count_d = count_q;
    endcase
  end

  // Occupancy register. Reset takes priority over flush and over any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_register_pipe_oe.sv
module tb_register_pipe_oe;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_i;
  logic          valid_i;
  logic          ready_i;
  logic          oe_i;
  logic [DW-1:0] data_i;

  logic          rdy_a, vo_a;
  logic [DW-1:0] do_a;
  logic [1:0]    cnt_a;
  logic          rdy_b, vo_b;
  logic [DW-1:0] do_b;
  logic [1:0]    cnt_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  register_pipe_oe #(.DATA_WIDTH(DW), .DEPTH(2)) u_dut_a (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rdy_a),
    .data_i(data_i), .valid_o(vo_a), .ready_i(ready_i), .OE_i(oe_i),
    .data_o(do_a), .count_o(cnt_a)
  );

  register_pipe_oe #(.DATA_WIDTH(DW), .DEPTH(3)) u_dut_b (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rdy_b),
    .data_i(data_i), .valid_o(vo_b), .ready_i(ready_i), .OE_i(oe_i),
    .data_o(do_b), .count_o(cnt_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        flush, vld, rdy, oe;
    logic [31:0] dat;
    logic        e_rdy, e_vld;
    logic [31:0] e_dat;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t vt[18];

  task automatic setv(input int i, input logic fl, input logic v, input logic [31:0] d,
                      input logic r, input logic oe, input logic er, input logic ev,
                      input logic [31:0] ed, input logic [1:0] ec);
    vt[i].flush = fl; vt[i].vld = v; vt[i].dat = d; vt[i].rdy = r; vt[i].oe = oe;
    vt[i].e_rdy = er; vt[i].e_vld = ev; vt[i].e_dat = ed; vt[i].e_cnt = ec;
  endtask

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int          pushed_a;

  // Scoreboard step for one DUT: compare against the queue model, then apply this cycle's transfers.
  task automatic sb(input int id, input int depth, input logic r_o, input logic v_o,
                    input logic [31:0] d_o, input logic [1:0] c_o);
    int          n;
    logic [31:0] front;
    string       tag;
    tag   = (id == 0) ? "a" : "b";
    n     = (id == 0) ? qa.size() : qb.size();
    front = '0;
    if (n > 0) front = (id == 0) ? qa[0] : qb[0];
    chk({"rand_cnt_", tag}, {30'd0, c_o}, n);
    chk({"rand_rdy_", tag}, {31'd0, r_o}, {31'd0, (n < depth) || ready_i});
    if (v_o) begin
      if (n == 0) begin
        chk({"rand_pop_empty_", tag}, 32'd1, 32'd0);
      end else begin
        chk({"rand_dat_", tag}, d_o, oe_i ? front : 32'd0);
        if (ready_i) begin
          if (id == 0) void'(qa.pop_front()); else void'(qb.pop_front());
        end
      end
    end else begin
      chk({"rand_idle_dat_", tag}, d_o, 32'd0);
    end
    if (valid_i && r_o) begin
      if (id == 0) begin qa.push_back(data_i); pushed_a++; end
      else qb.push_back(data_i);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; oe_i = 1'b1; data_i = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w[4];
    int          idx_in, idx_out;

    rst = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; oe_i = 1'b1; data_i = '0;

    // Reset state while rst is high
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_rdy_a", {31'd0, rdy_a}, 32'd0);
    chk("rst_vld_a", {31'd0, vo_a},  32'd0);
    chk("rst_dat_a", do_a,           32'd0);
    chk("rst_cnt_a", {30'd0, cnt_a}, 32'd0);
    chk("rst_rdy_b", {31'd0, rdy_b}, 32'd0);
    chk("rst_cnt_b", {30'd0, cnt_b}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_rdy_a", {31'd0, rdy_a}, 32'd1);
    chk("post_rst_rdy_b", {31'd0, rdy_b}, 32'd1);

    // Table on the DEPTH=2 instance: streaming, output enable, flush
    setv( 0, 0, 1, 32'h11,       1, 1, 1, 0, 32'h0,        0);
    setv( 1, 0, 1, 32'h22,       1, 1, 1, 0, 32'h0,        1);
    setv( 2, 0, 1, 32'h33,       1, 1, 1, 1, 32'h11,       2);
    setv( 3, 0, 0, 32'h0,        1, 1, 1, 1, 32'h22,       2);
    setv( 4, 0, 0, 32'h0,        1, 1, 1, 1, 32'h33,       1);
    setv( 5, 0, 0, 32'h0,        1, 1, 1, 0, 32'h0,        0);
    setv( 6, 0, 1, 32'hDEADBEEF, 0, 0, 1, 0, 32'h0,        0);
    setv( 7, 0, 0, 32'h0,        0, 0, 1, 0, 32'h0,        1);
    setv( 8, 0, 0, 32'h0,        0, 0, 1, 1, 32'h0,        1);
    setv( 9, 0, 0, 32'h0,        0, 1, 1, 1, 32'hDEADBEEF, 1);
    setv(10, 0, 0, 32'h0,        1, 1, 1, 1, 32'hDEADBEEF, 1);
    setv(11, 0, 0, 32'h0,        1, 1, 1, 0, 32'h0,        0);
    setv(12, 0, 1, 32'h44,       0, 1, 1, 0, 32'h0,        0);
    setv(13, 0, 1, 32'h55,       0, 1, 1, 0, 32'h0,        1);
    setv(14, 0, 1, 32'h66,       0, 1, 0, 1, 32'h44,       2);
    setv(15, 1, 1, 32'h77,       1, 1, 0, 0, 32'h0,        2);
    setv(16, 0, 0, 32'h0,        1, 1, 1, 0, 32'h0,        0);
    setv(17, 0, 0, 32'h0,        1, 1, 1, 0, 32'h0,        0);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      flush_i = vt[i].flush; valid_i = vt[i].vld; data_i = vt[i].dat;
      ready_i = vt[i].rdy;   oe_i    = vt[i].oe;
      #1;
      chk($sformatf("vec%0d_rdy", i), {31'd0, rdy_a}, {31'd0, vt[i].e_rdy});
      chk($sformatf("vec%0d_vld", i), {31'd0, vo_a},  {31'd0, vt[i].e_vld});
      chk($sformatf("vec%0d_dat", i), do_a,           vt[i].e_dat);
      chk($sformatf("vec%0d_cnt", i), {30'd0, cnt_a}, {30'd0, vt[i].e_cnt});
    end

    // Reset mid-stream on DEPTH=2 has priority over flush and transfers
    @(negedge clk);
    flush_i = 0; valid_i = 1; data_i = 32'h100; ready_i = 1; oe_i = 1;
    @(negedge clk);
    data_i = 32'h101;
    @(negedge clk);
    rst = 1; flush_i = 1; data_i = 32'h102;
    #1;
    chk("midrst_rdy", {31'd0, rdy_a}, 32'd0);
    chk("midrst_vld", {31'd0, vo_a},  32'd0);
    chk("midrst_dat", do_a,           32'd0);
    @(negedge clk);
    rst = 0; flush_i = 0; valid_i = 0;
    #1;
    chk("midrst_after_vld", {31'd0, vo_a},  32'd0);
    chk("midrst_after_dat", do_a,           32'd0);
    chk("midrst_after_cnt", {30'd0, cnt_a}, 32'd0);
    chk("midrst_after_rdy", {31'd0, rdy_a}, 32'd1);
    @(negedge clk);
    #1;
    chk("midrst_drop_vld", {31'd0, vo_a}, 32'd0);

    // DEPTH=3 instance fills under backpressure, then drains in order
    w[0] = 32'hA; w[1] = 32'hB; w[2] = 32'hC; w[3] = 32'hD;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ready_i = 0; oe_i = 1; valid_i = 1; data_i = w[i];
      #1;
      if (i < 3) begin
        chk($sformatf("fill%0d_rdy", i), {31'd0, rdy_b}, 32'd1);
      end else begin
        chk("full_rdy", {31'd0, rdy_b}, 32'd0);
        chk("full_cnt", {30'd0, cnt_b}, 32'd3);
      end
    end
    idx_in  = 3;
    idx_out = 0;
    for (int cyc = 0; cyc < 20 && idx_out < 4; cyc++) begin
      @(negedge clk);
      ready_i = 1;
      valid_i = (idx_in < 4);
      data_i  = (idx_in < 4) ? w[idx_in] : 32'h0;
      #1;
      if (vo_b) begin
        chk($sformatf("drain%0d_dat", idx_out), do_b, w[idx_out]);
        idx_out++;
      end
      if (valid_i && rdy_b) idx_in++;
    end
    chk("drain_words", idx_out, 32'd4);

    // Random handshake traffic on both instances against a queue scoreboard
    do_reset();
    pushed_a = 0;
    for (int cyc = 0; cyc < 20000 && pushed_a < 1000; cyc++) begin
      @(negedge clk);
      valid_i = ($urandom_range(0, 1) == 1);
      ready_i = ($urandom_range(0, 1) == 1);
      oe_i    = ($urandom_range(0, 3) != 0);
      data_i  = $urandom;
      #1;
      sb(0, 2, rdy_a, vo_a, do_a, cnt_a);
      sb(1, 3, rdy_b, vo_b, do_b, cnt_b);
    end
    chk("rand_words_a", pushed_a, 32'd1000);
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      valid_i = 0; ready_i = 1; oe_i = 1;
      #1;
      sb(0, 2, rdy_a, vo_a, do_a, cnt_a);
      sb(1, 3, rdy_b, vo_b, do_b, cnt_b);
    end
    chk("rand_left_a", qa.size(), 32'd0);
    chk("rand_left_b", qb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_pipe_oe.md
REGISTER_PIPE_OE -- requirements
Module: register_pipe_oe

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the payload width in bits (>=1).
REQ-002 Parameter DEPTH, default 2, SHALL set the number of register stages (>=1).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 flush_i  input  1  SHALL be the synchronous pipeline clear request.
REQ-006 valid_i  input  1  SHALL mark data_i as valid for upstream transfer.
REQ-007 ready_o  output  1  SHALL indicate the block accepts data_i this cycle.
REQ-008 data_i  input  DATA_WIDTH  SHALL be the upstream payload.
REQ-009 valid_o  output  1  SHALL mark data_o as valid for downstream transfer.
REQ-010 ready_i  input  1  SHALL indicate downstream accepts data_o this cycle.
REQ-011 OE_i  input  1  SHALL be the output enable; it gates data_o only.
REQ-012 data_o  output  DATA_WIDTH  SHALL be the gated output payload.
REQ-013 count_o  output  $clog2(DEPTH+1)  SHALL report the number of occupied stages.

Function
REQ-014 Each stage k (0..DEPTH-1) SHALL hold valid_q[k] and data_q[k]; stage 0 faces upstream, stage DEPTH-1 faces downstream.
REQ-015 Stage readiness SHALL be rdy[k] = ~valid_q[k] | rdy[k+1], with rdy[DEPTH] = ready_i; ready_o = rdy[0] (combinational path ready_i->ready_o accepted).
REQ-016 When rdy[k] is high, valid_q[k] SHALL load the upstream valid (valid_i for k=0, else valid_q[k-1]); data_q[k] SHALL load only if that upstream valid is high.
REQ-017 When rdy[k] is low, stage k SHALL hold valid_q[k] and data_q[k] unchanged.
REQ-018 Upstream transfer SHALL occur when valid_i & ready_o; downstream transfer when valid_o & ready_i.
REQ-019 valid_o SHALL equal valid_q[DEPTH-1].
REQ-020 data_o SHALL equal data_q[DEPTH-1] when OE_i & valid_o, otherwise all zeros (combinational gating).
REQ-021 OE_i SHALL NOT affect valid_o, ready_o, transfers or count_o.
REQ-022 Latency SHALL be DEPTH cycles from upstream transfer to valid_o with ready_i held high; throughput one word per cycle.
REQ-023 Bubbles SHALL collapse: an empty stage accepts even while downstream stalls; the pipe holds up to DEPTH words with ready_i low.
REQ-024 When all stages are valid and ready_i is low, ready_o SHALL be low (full); no word SHALL be lost or duplicated.
REQ-025 count_o SHALL be registered: +1 on upstream-only transfer, -1 on downstream-only transfer, unchanged when both or neither occur; it SHALL never exceed DEPTH or underflow.
REQ-026 When flush_i is high, ready_o and valid_o SHALL be forced low that cycle, all valid_q SHALL clear and count_o SHALL become 0 at the next edge; data_q SHALL hold.
REQ-027 Word order SHALL be preserved (strict FIFO).

Reset
REQ-028 On rst high at a rising edge, all valid_q SHALL clear, all data_q SHALL become 0, count_o SHALL become 0.
REQ-029 While rst is high, ready_o and valid_o SHALL be low and data_o SHALL be 0; rst SHALL take priority over flush_i and any transfer, including mid-stream.
REQ-030 After rst deasserts, ready_o SHALL be high in the first cycle.

Structure
REQ-031 No shared package is required; DATA_WIDTH and DEPTH SHALL be module parameters, count width derived locally.
REQ-032 One sub-module pipe_stage (one valid/data register pair with load enable and clear) SHALL be instantiated DEPTH times via generate.

Verification
REQ-033 DEPTH=2, ready_i=1, OE_i=1, stream 0x11,0x22,0x33 one per cycle -> valid_o 2 cycles after each input, data_o 0x11,0x22,0x33 back-to-back, count_o steady at 2 after fill.
REQ-034 DEPTH=3, ready_i=0, push 0xA,0xB,0xC,0xD -> first three accepted, ready_o low on fourth, count_o=3; raise ready_i -> 0xA,0xB,0xC then 0xD out in order.
REQ-035 Word 0xDEADBEEF at output, OE_i=0 -> data_o=0, valid_o=1; OE_i=1 -> data_o=0xDEADBEEF; handshake unaffected.
REQ-036 Pipe holding 2 words, assert flush_i one cycle with valid_i=1 -> ready_o/valid_o low that cycle, next cycle valid_o=0, count_o=0, input word dropped.
REQ-037 Assert rst mid-stream with ready_i=1 -> next cycle valid_o=0, data_o=0, count_o=0; after release ready_o=1.
REQ-038 Random valid_i/ready_i toggling, 1000 words -> scoreboard shows no loss, duplication or reordering; count_o matches model every cycle.
